// File: rtl/cam_fifo_bridge.sv
// Data-side bridge: passes core loads/stores to the data RAM and exposes a
// camera pixel FIFO plus its status/control registers in a 16-byte window.
module cam_fifo_bridge #(
   parameter int          DEPTH      = 16,
   parameter logic [31:0] CAM_BASE   = 32'h0000_1000,
   parameter int          IRQ_THRESH = 8
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] ALUResult,
   input  logic [31:0] WriteData,
   input  logic        write_enable,
   input  logic        mem_read,
   output logic [31:0] ReadData,
   output logic        ram_wren,
   input  logic [31:0] ram_q,
   input  logic [7:0]  cam_pixel,
   input  logic        cam_valid,
   output logic        cam_ready,
   input  logic        cam_frame_start,
   output logic        irq
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;

   typedef enum logic [1:0] {
      REG_DATA   = 2'd0,
      REG_STATUS = 2'd1,
      REG_CTRL   = 2'd2,
      REG_FRAME  = 2'd3
   } reg_off_e;

   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             overflow_q, overflow_d;
   logic             enable_q, enable_d;
   logic             irq_q, irq_d;
   logic             hit_q, hit_d;
   logic [15:0]      frame_q, frame_d;
   logic [31:0]      rdata_q, rdata_d;
   logic [7:0]       mem_q [DEPTH];

   logic     cam_hit, full, empty, push, pop, ctrl_wr, flush;
   reg_off_e offset;
   logic     unused_bits;

   assign unused_bits = ^{WriteData[31:3], ALUResult[1:0]};

   always_comb begin
      cam_hit   = (ALUResult[31:4] == CAM_BASE[31:4]);
      offset    = reg_off_e'(ALUResult[3:2]);
      full      = (count_q == CNT_W'(DEPTH));
      empty     = (count_q == '0);
      // Ready comes only from registered state so the camera never sees a
      // combinational path from the core's address bus.
      cam_ready = enable_q & ~full;
      push      = cam_valid & cam_ready;
      pop       = mem_read & cam_hit & (offset == REG_DATA) & ~empty;
      ctrl_wr   = write_enable & cam_hit & (offset == REG_CTRL);
      flush     = ctrl_wr & WriteData[2];
      ram_wren  = write_enable & ~cam_hit;
   end

   // NOTE: every variable gets a default first so no path leaves it unassigned (no latches).
   always_comb begin
      rd_ptr_d   = rd_ptr_q;
      wr_ptr_d   = wr_ptr_q;
      count_d    = count_q;
      enable_d   = ctrl_wr ? WriteData[0] : enable_q;
      overflow_d = (cam_valid & enable_q & full) | (overflow_q & ~(ctrl_wr & WriteData[1]));
      frame_d    = (cam_frame_start & enable_q) ? frame_q + 16'd1 : frame_q;
      irq_d      = enable_q & (int'(count_q) >= IRQ_THRESH);
      hit_d      = mem_read & cam_hit;

      if (flush) begin
         rd_ptr_d = '0;
         wr_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
         endcase
      end

      rdata_d = '0;
      case (offset)
         REG_DATA:   rdata_d = empty ? 32'h0 : {1'b1, 23'b0, mem_q[rd_ptr_q]};
         REG_STATUS: rdata_d = {16'(count_q), 12'b0, overflow_q, irq_q, full, empty};
         REG_CTRL:   rdata_d = {31'b0, enable_q};
         REG_FRAME:  rdata_d = {16'b0, frame_q};
         default:    rdata_d = '0;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all flops sample pre-edge values.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_ptr_q   <= '0;
         wr_ptr_q   <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
         enable_q   <= 1'b0;
         irq_q      <= 1'b0;
         hit_q      <= 1'b0;
         frame_q    <= '0;
         rdata_q    <= '0;
      end else begin
         rd_ptr_q   <= rd_ptr_d;
         wr_ptr_q   <= wr_ptr_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
         enable_q   <= enable_d;
         irq_q      <= irq_d;
         hit_q      <= hit_d;
         frame_q    <= frame_d;
         rdata_q    <= rdata_d;
      end
   end

   // NOTE: pixel storage has no reset; the zeroed pointers make stale entries unreachable.
   always_ff @(posedge clk) begin
      if (push && !flush) mem_q[wr_ptr_q] <= cam_pixel;
   end

   assign irq      = irq_q;
   assign ReadData = hit_q ? rdata_q : ram_q;

endmodule

// File: tb/tb_cam_fifo_bridge.sv
// Self-checking bench for cam_fifo_bridge: directed vector table, corner
// sequences and a randomized run against a queue-based reference model.
module tb_cam_fifo_bridge;

   localparam int          DEPTH      = 16;
   localparam logic [31:0] CAM_BASE   = 32'h0000_1000;
   localparam int          IRQ_THRESH = 8;
   localparam logic [31:0] A_DATA     = CAM_BASE;
   localparam logic [31:0] A_STAT     = CAM_BASE + 32'h4;
   localparam logic [31:0] A_CTRL     = CAM_BASE + 32'h8;
   localparam logic [31:0] A_FRAME    = CAM_BASE + 32'hC;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] ALUResult, WriteData, ReadData, ram_q;
   logic        write_enable, mem_read, ram_wren;
   logic [7:0]  cam_pixel;
   logic        cam_valid, cam_ready, cam_frame_start, irq;

   always #5 clk = ~clk;

   cam_fifo_bridge #(.DEPTH(DEPTH), .CAM_BASE(CAM_BASE), .IRQ_THRESH(IRQ_THRESH)) dut (
      .clk(clk), .reset(reset), .ALUResult(ALUResult), .WriteData(WriteData),
      .write_enable(write_enable), .mem_read(mem_read), .ReadData(ReadData),
      .ram_wren(ram_wren), .ram_q(ram_q), .cam_pixel(cam_pixel), .cam_valid(cam_valid),
      .cam_ready(cam_ready), .cam_frame_start(cam_frame_start), .irq(irq)
   );

   // Synchronous data RAM fixture (read-before-write)
   logic [31:0] ram_mem [256];
   always_ff @(posedge clk) begin
      if (ram_wren) ram_mem[ALUResult[9:2]] <= WriteData;
      ram_q <= ram_mem[ALUResult[9:2]];
   end

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Reference model state
   logic [7:0]  mq[$];
   logic [31:0] m_ram [int];
   bit          m_en, m_ovf, m_irq;
   int          m_frame;
   bit          exp_rd_pend;
   logic [31:0] exp_rd;

   logic [31:0] s_rd;
   logic        s_wren, s_ready, s_irq;

   // One clock: called at a falling edge, drives inputs, checks, advances model.
   task automatic cycle(input logic [31:0] addr, input logic [31:0] wd, input bit we,
                        input bit rd, input logic [7:0] pix, input bit vld, input bit fs);
      bit          hit, full, rdy, pop, push, flush, ctrlw, irq_n;
      logic [1:0]  off;
      logic [31:0] regv;
      int          sz, idx;
      ALUResult = addr; WriteData = wd; write_enable = we; mem_read = rd;
      cam_pixel = pix; cam_valid = vld; cam_frame_start = fs;
      #1;
      s_rd = ReadData; s_wren = ram_wren; s_ready = cam_ready; s_irq = irq;
      hit  = (addr[31:4] == CAM_BASE[31:4]);
      off  = addr[3:2];
      idx  = int'(addr[9:2]);
      sz   = mq.size();
      full = (sz == DEPTH);
      rdy  = m_en && !full;
      check("cam_ready", cam_ready, rdy);
      check("ram_wren", ram_wren, we && !hit);
      check("irq", irq, m_irq);
      if (exp_rd_pend) check("ReadData", ReadData, exp_rd);

      case (off)
         2'd0:    regv = (sz > 0) ? {1'b1, 23'b0, mq[0]} : 32'h0;
         2'd1:    regv = {16'(sz), 12'b0, m_ovf, m_irq, full, sz == 0};
         2'd2:    regv = {31'b0, m_en};
         default: regv = {16'b0, 16'(m_frame)};
      endcase
      exp_rd_pend = 1'b0;
      if (rd && hit) begin
         exp_rd_pend = 1'b1; exp_rd = regv;
      end else if (rd && m_ram.exists(idx)) begin
         exp_rd_pend = 1'b1; exp_rd = m_ram[idx];
      end

      ctrlw = we && hit && off == 2'd2;
      flush = ctrlw && wd[2];
      pop   = rd && hit && off == 2'd0 && sz > 0;
      push  = vld && rdy;
      irq_n = m_en && sz >= IRQ_THRESH;
      if (vld && m_en && full) m_ovf = 1'b1;
      else if (ctrlw && wd[1]) m_ovf = 1'b0;
      if (fs && m_en) m_frame = (m_frame + 1) % 65536;
      if (flush) mq.delete();
      else begin
         if (pop)  void'(mq.pop_front());
         if (push) mq.push_back(pix);
      end
      if (ctrlw) m_en = wd[0];
      if (we && !hit) m_ram[idx] = wd;
      m_irq = irq_n;
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic idle();                                     cycle(32'h0, 32'h0, 0, 0, 8'h0, 0, 0); endtask
   task automatic ld(input logic [31:0] a);                   cycle(a, 32'h0, 0, 1, 8'h0, 0, 0);     endtask
   task automatic st(input logic [31:0] a, input logic [31:0] d); cycle(a, d, 1, 0, 8'h0, 0, 0);    endtask
   task automatic px(input logic [7:0] p);                    cycle(32'h0, 32'h0, 0, 0, p, 1, 0);    endtask

   // Asynchronous reset asserted between clock edges, released on a falling edge.
   task automatic apply_reset();
      reset = 1'b0;
      #1;
      check("rst_cam_ready", cam_ready, 1'b0);
      check("rst_irq", irq, 1'b0);
      check("rst_readdata_is_ram_q", ReadData, ram_q);
      mq.delete();
      m_en = 0; m_ovf = 0; m_irq = 0; m_frame = 0; exp_rd_pend = 0;
      repeat (2) @(negedge clk);
      check("rst_hold_readdata", ReadData, ram_q);
      reset = 1'b1;
   endtask

   typedef struct {
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        we;
      logic        rd;
      logic        exp_wren;
      logic        chk_rd;
      logic [31:0] exp_rd;
   } vec_t;

   vec_t vecs[12];

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      vecs[0]  = '{32'h20,  32'hDEADBEEF, 1, 0, 1, 0, 32'h0};
      vecs[1]  = '{32'h20,  32'h0,        0, 1, 0, 0, 32'h0};
      vecs[2]  = '{A_STAT,  32'hFFFFFFFF, 1, 0, 0, 1, 32'hDEADBEEF};
      vecs[3]  = '{A_STAT,  32'h0,        0, 1, 0, 0, 32'h0};
      vecs[4]  = '{A_CTRL,  32'h1,        1, 0, 0, 1, 32'h0000_0001};
      vecs[5]  = '{A_CTRL,  32'h0,        0, 1, 0, 0, 32'h0};
      vecs[6]  = '{A_FRAME, 32'h0,        0, 1, 0, 1, 32'h0000_0001};
      vecs[7]  = '{A_DATA,  32'h0,        0, 1, 0, 1, 32'h0};
      vecs[8]  = '{A_FRAME, 32'h1234,     1, 0, 0, 1, 32'h0};
      vecs[9]  = '{32'h20,  32'h0,        0, 1, 0, 0, 32'h0};
      vecs[10] = '{A_FRAME, 32'h0,        0, 1, 0, 1, 32'hDEADBEEF};
      vecs[11] = '{32'h0,   32'h0,        0, 0, 0, 1, 32'h0};

      reset = 1'b0; ALUResult = '0; WriteData = '0; write_enable = 0; mem_read = 0;
      cam_pixel = '0; cam_valid = 0; cam_frame_start = 0;
      m_en = 0; m_ovf = 0; m_irq = 0; m_frame = 0; exp_rd_pend = 0;
      repeat (3) @(negedge clk);
      #1;
      check("init_cam_ready", cam_ready, 1'b0);
      check("init_irq", irq, 1'b0);
      check("init_readdata_is_ram_q", ReadData, ram_q);
      @(negedge clk);
      reset = 1'b1;

      // Directed table: RAM pass-through, register reads, ignored stores
      for (int i = 0; i < 12; i++) begin
         cycle(vecs[i].addr, vecs[i].wdata, vecs[i].we, vecs[i].rd, 8'h0, 0, 0);
         check($sformatf("vec%0d_wren", i), s_wren, vecs[i].exp_wren);
         if (vecs[i].chk_rd) check($sformatf("vec%0d_rdata", i), s_rd, vecs[i].exp_rd);
      end

      // Fill to full
      for (int i = 1; i <= DEPTH; i++) px(8'(i));
      ld(A_STAT);
      check("fill_ready_dropped", s_ready, 1'b0);
      idle();
      check("fill_status", s_rd, 32'h0010_0006);
      check("fill_irq", s_irq, 1'b1);

      // Overflow while full, then W1C clear
      repeat (3) px(8'hAA);
      ld(A_STAT); idle();
      check("ovf_status", s_rd, 32'h0010_000E);
      st(A_CTRL, 32'h3);
      ld(A_STAT); idle();
      check("ovf_cleared_status", s_rd, 32'h0010_0006);
      ld(A_CTRL); idle();
      check("ovf_clear_keeps_enable", s_rd, 32'h1);

      // Pop order, then read past empty
      for (int i = 0; i <= DEPTH; i++) begin
         ld(A_DATA);
         if (i > 0) check($sformatf("pop%0d", i), s_rd, 32'h8000_0000 | 32'(i));
      end
      idle();
      check("empty_read", s_rd, 32'h0);
      ld(A_STAT); idle();
      check("empty_bit", 32'(s_rd[0]), 32'h1);

      // Simultaneous push and pop at count 5
      for (int i = 0; i < 5; i++) px(8'(8'h21 + i));
      cycle(A_DATA, 32'h0, 0, 1, 8'h26, 1, 0);
      ld(A_STAT);
      check("pushpop_head", s_rd, 32'h8000_0021);
      idle();
      check("pushpop_count5", s_rd, 32'h0005_0000);

      // Randomized mix; pointer wrap happens many times over
      for (int n = 0; n < 500; n++) begin
         int          r;
         logic [31:0] a, d;
         bit          vld, fs;
         r   = $urandom_range(0, 99);
         vld = ($urandom_range(0, 99) < 60);
         fs  = ($urandom_range(0, 19) == 0);
         a   = 32'($urandom_range(0, 255)) << 2;
         d   = $urandom;
         if (r < 35)      cycle(A_DATA,  32'h0, 0, 1, 8'($urandom), vld, fs);
         else if (r < 45) cycle(A_STAT,  32'h0, 0, 1, 8'($urandom), vld, fs);
         else if (r < 48) cycle(A_FRAME, 32'h0, 0, 1, 8'($urandom), vld, fs);
         else if (r < 50) cycle(A_CTRL, {29'b0, $urandom_range(0, 3) == 0, 1'($urandom),
                                         $urandom_range(0, 7) != 0}, 1, 0, 8'($urandom), vld, fs);
         else if (r < 55) cycle(a, d, 1, 0, 8'($urandom), vld, fs);
         else if (r < 60) cycle(a, 32'h0, 0, 1, 8'($urandom), vld, fs);
         else             cycle(32'h0, 32'h0, 0, 0, 8'($urandom), vld, fs);
      end
      idle();

      // Flush with a same-cycle pixel
      st(A_CTRL, 32'h3);
      repeat (4) px(8'h5A);
      cycle(A_CTRL, 32'h5, 1, 0, 8'h77, 1, 0);
      ld(A_STAT); idle();
      check("flush_count_empty", s_rd & 32'hFFFF_0001, 32'h0000_0001);
      ld(A_CTRL); idle();
      check("flush_keeps_enable", s_rd, 32'h1);
      ld(A_DATA); idle();
      check("flush_pixel_dropped", s_rd, 32'h0);

      // Reset in the middle of a push burst
      repeat (3) px(8'h99);
      cam_valid = 1'b1;
      apply_reset();
      ld(A_STAT); idle();
      check("post_rst_status", s_rd, 32'h0000_0001);
      ld(A_CTRL); idle();
      check("post_rst_ctrl", s_rd, 32'h0);
      px(8'h42);
      check("post_rst_ready", s_ready, 1'b0);

      // Frame counter: pulse while disabled is ignored, three enabled pulses count
      cycle(32'h0, 32'h0, 0, 0, 8'h0, 0, 1);
      st(A_CTRL, 32'h1);
      repeat (3) begin
         cycle(32'h0, 32'h0, 0, 0, 8'h0, 0, 1);
         idle();
      end
      ld(A_FRAME); idle();
      check("frame_count3", s_rd, 32'h3);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
